mem_responder: RTL and testbench

Word-addressed memory responder that serves load/store requests from the multicycle CPU over a request/acknowledge handshake with programmable wait states. It owns a single-port word array, captures each request in one cycle, inserts `WAIT_CYCLES` latency, then returns one acknowledge pulse with read data or a misalignment error. It sits between the CPU's address mux (PC or ALU result) and storage. It replaces the zero-latency memory path, so the controller FSM must stall until `Ack` is asserted.

---
 rtl/mem_responder.sv | 130 +++++++++++++
 tb/tb_mem_responder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: word-addressed single-port memory behind a req/ack handshake.
// A request is captured in IDLE, held for WAIT_CYCLES wait states, then
// acknowledged with one Ack pulse carrying load data or a misalignment error.
module mem_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        Wr,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        Ack,
    output logic        Err,
    output logic        Busy
);

    localparam int IDX_HI = DEPTH_LOG2 + 1;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state, state_next;
    logic [3:0] cnt, cnt_next;
    logic capture;

    // Captured request; only control is reset, these are qualified by the FSM.
    logic            wr_p0;
    logic [IDX_HI:0] addr_p0;
    logic [31:0]     data_p0;

    // Fields of the request being completed. With zero wait states the access
    // happens on the capture edge itself, so the live inputs are used then.
    logic                  acc_wr;
    logic [IDX_HI:0]       acc_addr;
    logic [31:0]           acc_data;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic                  enter_resp;
    logic                  misalign;
    logic                  mem_we;
    logic                  mem_re;

    logic [31:0] mem [2**DEPTH_LOG2];

    // Upper address bits only alias; they never select storage.
    logic unused_addr_bits;
    assign unused_addr_bits = ^Address[31:IDX_HI+1];

    // Next-state, counter and array-access decode.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        case (state)
            S_IDLE: begin
                if (Req) begin
                    capture    = 1'b1;
                    cnt_next   = CNT_INIT;
                    state_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = S_RESP;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        acc_wr     = capture ? Wr : wr_p0;
        acc_addr   = capture ? Address[IDX_HI:0] : addr_p0;
        acc_data   = capture ? DataIn : data_p0;
        acc_idx    = acc_addr[IDX_HI:2];
        enter_resp = (state_next == S_RESP);
        misalign   = |acc_addr[1:0];
        mem_we     = Reset & enter_resp & acc_wr & ~misalign;
        mem_re     = enter_resp & ~acc_wr & ~misalign;
    end

    // FSM state, wait counter and registered outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            Ack     <= 1'b0;
            Err     <= 1'b0;
            Busy    <= 1'b0;
            DataOut <= 32'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            Ack   <= enter_resp;
            Err   <= enter_resp & misalign;
            Busy  <= (state_next != S_IDLE);
            if (mem_re) begin
                DataOut <= mem[acc_idx];
            end
        end
    end

    // Request capture register, loaded only on an accepted request.
    always_ff @(posedge Clk) begin
        if (capture) begin
            wr_p0   <= Wr;
            addr_p0 <= Address[IDX_HI:0];
            data_p0 <= DataIn;
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[acc_idx] <= acc_data;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder with a vector table for
// single transactions and hand-written sequences for multi-cycle corners.
module tb_mem_responder;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Req = 1'b0;
    logic        Req0 = 1'b0;
    logic        Wr = 1'b0;
    logic [31:0] Address = 32'd0;
    logic [31:0] DataIn = 32'd0;

    logic [31:0] DataOut, DataOut0;
    logic        Ack, Err, Busy;
    logic        Ack0, Err0, Busy0;

    int tests  = 0;
    int failed = 0;

    always #5 Clk = ~Clk;

    mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Wr(Wr), .Address(Address),
        .DataIn(DataIn), .DataOut(DataOut), .Ack(Ack), .Err(Err), .Busy(Busy)
    );

    mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut0 (
        .Clk(Clk), .Reset(Reset), .Req(Req0), .Wr(Wr), .Address(Address),
        .DataIn(DataIn), .DataOut(DataOut0), .Ack(Ack0), .Err(Err0), .Busy(Busy0)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] exp_dout;
        logic        exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Issue one request on the WAIT_CYCLES=2 instance; returns in the Ack cycle.
    task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] din,
                          output int lat);
        Wr      = wr;
        Address = addr;
        DataIn  = din;
        Req     = 1'b1;
        tick();
        Req = 1'b0;
        lat = 1;
        while (!Ack && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;

        // Reset state
        #1 Reset = 1'b0;
        #2;
        check("rst_ack",   Ack,      0);
        check("rst_err",   Err,      0);
        check("rst_busy",  Busy,     0);
        check("rst_dout",  DataOut,  0);
        check("rst_ack0",  Ack0,     0);
        check("rst_err0",  Err0,     0);
        check("rst_busy0", Busy0,    0);
        check("rst_dout0", DataOut0, 0);
        tick();
        tick();
        Reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_busy", Busy, 0);
            check("idle_ack",  Ack,  0);
        end

        // Single transactions, expected DataOut tracks the last successful load
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_0013, 32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b1};
        vecs[3] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_0020, 32'h1111_1111, 32'hDEAD_BEEF, 1'b0};
        vecs[5] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 32'h1111_1111, 1'b0};
        vecs[6] = '{1'b0, 32'h0000_0022, 32'h0000_0000, 32'h1111_1111, 1'b1};
        vecs[7] = '{1'b1, 32'h0000_0000, 32'h55AA_55AA, 32'h1111_1111, 1'b0};
        vecs[8] = '{1'b0, 32'h0000_0400, 32'h0000_0000, 32'h55AA_55AA, 1'b0};

        for (int i = 0; i < 9; i++) begin
            do_txn(vecs[i].wr, vecs[i].addr, vecs[i].din, lat);
            check($sformatf("v%0d_latency", i), lat, 3);
            check($sformatf("v%0d_dout", i), DataOut, vecs[i].exp_dout);
            check($sformatf("v%0d_err", i), Err, vecs[i].exp_err);
            tick();
            check($sformatf("v%0d_busy_after", i), Busy, 0);
        end

        // Back-to-back with Req held high; second request set up during WAIT
        Wr = 1'b1; Address = 32'h0000_0404; DataIn = 32'h1234_5678; Req = 1'b1;
        tick();
        check("b2b_busy_e0", Busy, 1);
        Wr = 1'b0; Address = 32'h0000_0004; DataIn = 32'hFFFF_FFFF;
        tick();
        check("b2b_ack_e1", Ack, 0);
        tick();
        check("b2b_ack1", Ack, 1);
        check("b2b_err1", Err, 0);
        tick();
        check("b2b_idle_busy", Busy, 0);
        check("b2b_idle_ack",  Ack,  0);
        tick();
        check("b2b_capture2", Busy, 1);
        Req = 1'b0;
        tick();
        check("b2b_ack2_early", Ack, 0);
        tick();
        check("b2b_ack2", Ack, 1);
        check("b2b_dout", DataOut, 32'h1234_5678);
        check("b2b_err2", Err, 0);
        tick();

        // Reset during WAIT of a store drops it
        Wr = 1'b1; Address = 32'h0000_0020; DataIn = 32'hAAAA_0000; Req = 1'b1;
        tick();
        Req = 1'b0;
        tick();
        check("rmid_busy_wait", Busy, 1);
        Reset = 1'b0;
        #1;
        check("rmid_busy", Busy, 0);
        check("rmid_ack",  Ack,  0);
        check("rmid_dout", DataOut, 0);
        tick();
        tick();
        #2 Reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rmid_no_ack", Ack, 0);
        end
        do_txn(1'b0, 32'h0000_0020, 32'h0, lat);
        check("rmid_load_lat",  lat, 3);
        check("rmid_load_dout", DataOut, 32'h1111_1111);
        check("rmid_load_err",  Err, 0);
        tick();

        // Zero wait states
        Wr = 1'b1; Address = 32'h0000_0008; DataIn = 32'h0BAD_CAFE; Req0 = 1'b1;
        tick();
        check("zw_st_ack",  Ack0,  1);
        check("zw_st_busy", Busy0, 1);
        check("zw_st_err",  Err0,  0);
        Req0 = 1'b0;
        tick();
        check("zw_st_ack_end",  Ack0,  0);
        check("zw_st_busy_end", Busy0, 0);
        Wr = 1'b0; Req0 = 1'b1;
        tick();
        check("zw_ld_ack",  Ack0,  1);
        check("zw_ld_dout", DataOut0, 32'h0BAD_CAFE);
        check("zw_ld_busy", Busy0, 1);
        Req0 = 1'b0;
        tick();
        check("zw_ld_busy_end", Busy0, 0);
        check("zw_ld_ack_end",  Ack0,  0);
        Address = 32'h0000_000A; Req0 = 1'b1;
        tick();
        check("zw_mis_err",  Err0, 1);
        check("zw_mis_dout", DataOut0, 32'h0BAD_CAFE);
        Req0 = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
